load_store_unit: RTL and testbench

Memory-stage load/store unit between the execute/memory pipeline register and the word-wide data memory. Turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Sub-word stores use read-modify-write because the memory has a single whole-word write enable. Loads are sign- or zero-extended, and the pipeline is stalled through `req_ready` while an access is in flight.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_lane_align.sv | 38 +++
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and decode helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  // Access size lives in funct3[1:0]; funct3[2] selects zero-extension.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE
  } lsu_state_e;

  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_H:    return lo[0];
      SZ_W:    return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends a load lane and merges sub-word
// store data into the word read back from memory.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] rd_word_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [2:0]        funct3_i,
  input  logic [HALF_W-1:0] st_data_i,
  output logic [WORD_W-1:0] ld_data_o,
  output logic [WORD_W-1:0] merged_o
);

  logic [BYTE_W-1:0] byte_v;
  logic [HALF_W-1:0] half_v;
  logic              zext;

  always_comb begin
    byte_v    = BYTE_W'(rd_word_i >> {addr_lo_i, 3'b000});
    half_v    = HALF_W'(rd_word_i >> {addr_lo_i[1], 4'b0000});
    zext      = funct3_i[2];
    ld_data_o = rd_word_i;
    merged_o  = rd_word_i;
    case (funct3_i[1:0])
      SZ_B: begin
        ld_data_o = zext ? {24'd0, byte_v} : {{24{byte_v[BYTE_W-1]}}, byte_v};
        merged_o[{addr_lo_i, 3'b000} +: BYTE_W] = st_data_i[BYTE_W-1:0];
      end
      SZ_H: begin
        // addr[0] never selects a half, so an unaligned half folds down.
        ld_data_o = zext ? {16'd0, half_v} : {{16{half_v[HALF_W-1]}}, half_v};
        merged_o[{addr_lo_i[1], 4'b0000} +: HALF_W] = st_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: word memory access with read-modify-write sub-word stores.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned H/W accesses).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  lsu_state_e          state_q;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   merge_q;
  logic                rsp_valid_q;
  logic [WORD_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic [WORD_W-1:0]   ld_data;
  logic [WORD_W-1:0]   merged;
  logic                misalign_err;
  logic                access_err;
  logic                is_word;
  logic                sw_access;
  logic                unused_addr_hi;

  // Address bits above the memory size wrap silently.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_err = is_misaligned(f3_q[1:0], addr_q[1:0]);
`else
  assign misalign_err = 1'b0;
`endif

  assign access_err = is_illegal_f3(f3_q) || misalign_err;
  assign is_word    = (f3_q[1:0] == SZ_W);
  assign sw_access  = (state_q == S_ACCESS) && we_q && is_word && !access_err;

  lsu_lane_align u_lane_align (
    .rd_word_i (mem_rd),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (f3_q),
    .st_data_i (wdata_q[HALF_W-1:0]),
    .ld_data_o (ld_data),
    .merged_o  (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      merge_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          state_q <= S_IDLE;
          if (access_err) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else if (!we_q) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= ld_data;
          end else if (is_word) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end else begin
            merge_q <= merged;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write strobe is gated by rst so an aborted access never reaches memory.
  assign mem_we    = !rst && (sw_access || (state_q == S_WRITE));
  assign mem_wd    = sw_access ? wdata_q : ((state_q == S_WRITE) ? merge_q : '0);
  assign mem_a     = {{(32 - ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// against a behavioural memory/response model.
module tb_load_store_unit;

  localparam int DEPTH = 1024;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        bk_we;
  logic [9:0]  bk_idx;
  logic [31:0] bk_data;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:0]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[9:0]] <= mem_wd;
    else if (bk_we) mem[bk_idx] <= bk_data;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    bk_we = 1'b1; bk_idx = idx[9:0]; bk_data = val;
    @(negedge clk);
    bk_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Expected response per RV32I rules; updates ref_mem for stores.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rdata,
                                output bit err, output int lat, output int wcyc);
    int widx = int'((addr >> 2) % DEPTH);
    int off  = int'(addr % 4);
    int sz   = int'(f3 % 4);
    int hoff = (off / 2) * 2;
    int v;
    logic [31:0] w    = ref_mem[widx];
    logic [31:0] mask;
    bit illegal = (f3 == 3) || (f3 == 6) || (f3 == 7);
    bit mis     = TRAP && ((sz == 1 && off % 2 == 1) || (sz == 2 && off != 0));
    err = illegal || mis;
    rdata = 0; lat = 2; wcyc = 0;
    if (err) return;
    if (!we) begin
      if (sz == 0) begin
        v = int'((w >> (8 * off)) & 32'hFF);
        if (f3 < 4 && v >= 128) v = v - 256;
        rdata = v;
      end else if (sz == 1) begin
        v = int'((w >> (8 * hoff)) & 32'hFFFF);
        if (f3 < 4 && v >= 32768) v = v - 65536;
        rdata = v;
      end else begin
        rdata = w;
      end
    end else if (sz == 2) begin
      ref_mem[widx] = wd;
      wcyc = 1;
    end else begin
      if (sz == 0) begin
        mask = 32'hFF << (8 * off);
        ref_mem[widx] = (w & ~mask) | ((wd & 32'hFF) << (8 * off));
      end else begin
        mask = 32'hFFFF << (8 * hoff);
        ref_mem[widx] = (w & ~mask) | ((wd & 32'hFFFF) << (8 * hoff));
      end
      lat = 3; wcyc = 2;
    end
  endfunction

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat, exp_wc, lat, wait_n;
    logic [7:0]  we_mask, exp_mask;
    int          widx = int'((addr >> 2) % DEPTH);
    wait_n = 0;
    @(negedge clk);
    while (!req_ready && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    model(we, f3, addr, wd, exp_rd, exp_err, exp_lat, exp_wc);
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom % 2; req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    check({tag, "_mem_a"}, mem_a, widx);
    check({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
    lat = 0; we_mask = '0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_we) we_mask[c-1] = 1'b1;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    exp_mask = (exp_wc == 0) ? 8'd0 : 8'(1 << (exp_wc - 1));
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_we_cycles"}, {24'd0, we_mask}, {24'd0, exp_mask});
    check({tag, "_ready_rsp"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_memword"}, mem[widx], ref_mem[widx]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_wd"}, mem_wd, 32'd0);
    check({tag, "_mem_a"}, mem_a, 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bit          we;
    int          ld_f3 [5] = '{0, 1, 2, 4, 5};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; bk_we = 1'b0; bk_idx = '0; bk_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 32; i++) poke(i, $urandom);

    // SW then LW
    do_req(1, 3'd2, 32'h40, 32'hDEADBEEF, "sw40");
    check("sw40_word16", mem[16], 32'hDEADBEEF);
    do_req(0, 3'd2, 32'h40, 32'h0, "lw40");

    // SB read-modify-write
    poke(16, 32'h11223344);
    do_req(1, 3'd0, 32'h42, 32'h000000AA, "sb42");
    check("sb42_word16", mem[16], 32'h11AA3344);

    // sign / zero extension
    poke(16, 32'h0000F080);
    do_req(0, 3'd0, 32'h40, 0, "lb40");
    do_req(0, 3'd4, 32'h40, 0, "lbu40");
    do_req(0, 3'd1, 32'h40, 0, "lh40");
    do_req(0, 3'd5, 32'h42, 0, "lhu42");

    // misaligned store, illegal funct3 and address wrap
    do_req(1, 3'd2, 32'h41, 32'hCAFEF00D, "sw41");
    do_req(0, 3'd3, 32'h40, 0, "ill3");
    do_req(1, 3'd7, 32'h44, 32'h12345678, "ill7");
    do_req(0, 3'd2, 32'hFFFF_F040, 0, "lw_wrap");

    // reset in WRITE cycle of SH
    poke(16, 32'h11223344);
    do_req(0, 3'd4, 32'h40, 0, "pre_abort");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h42; req_wdata = 32'h5566;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_we_before_rst", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_we_during_rst", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_valid", {31'd0, rsp_valid}, 32'd0);
    end
    check("abort_word16", mem[16], 32'h11223344);

    // back-to-back with req_valid held
    poke(20, 32'hA5A5_0001);
    poke(21, 32'h5A5A_0002);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h50;
    @(negedge clk);
    req_addr = 32'h54;
    check("b2b_busy1", {31'd0, req_ready}, 32'd0);
    check("b2b_novalid1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("b2b_valid1", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rdata1", rsp_rdata, 32'hA5A5_0001);
    check("b2b_ready1", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_busy2", {31'd0, req_ready}, 32'd0);
    check("b2b_novalid2", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("b2b_valid2", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rdata2", rsp_rdata, 32'h5A5A_0002);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom % 2);
      if ($urandom % 10 == 0) f3 = ($urandom % 2) ? 3'd3 : 3'(6 + $urandom % 2);
      else if (we) f3 = 3'($urandom % 3);
      else f3 = 3'(ld_f3[$urandom % 5]);
      a = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      if ($urandom % 4 == 0) a = a | ($urandom << 12);
      do_req(we, f3, a, $urandom, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
